// File: rtl/sample_reader_if.sv
// Purpose : groups the control, sample-memory and UART handshake signals of sample_reader.
// Latency : none; plain wires between the reader and its environment.
// Backpressure: the UART side holds the reader off through tx_active and tx_done.
//
// Signals:
//   activate  env -> reader  level request, high = run one frame
//   done      reader -> env  frame complete, held until activate falls
//   mem_addr  reader -> mem  read address for the asynchronous-read sample memory
//   mem_oe    reader -> mem  output enable, high while a sample is being fetched
//   mem_data  mem -> reader  read data, combinationally valid for mem_addr
//   tx_data   reader -> uart byte to transmit
//   tx_start  reader -> uart one-cycle start pulse
//   tx_active uart -> reader transmitter busy
//   tx_done   uart -> reader one-cycle pulse when a byte has left the transmitter
interface sample_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  activate;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_oe;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_active;
  logic                  tx_done;

  // The reader drives the memory address and the UART request side.
  modport master (
    input  activate, mem_data, tx_active, tx_done,
    output done, mem_addr, mem_oe, tx_data, tx_start
  );

  // The environment (top-level watcher, memory, UART) sees the mirror image.
  modport slave (
    output activate, mem_data, tx_active, tx_done,
    input  done, mem_addr, mem_oe, tx_data, tx_start
  );
endinterface

// File: rtl/sample_reader.sv
// Purpose : streams one frame (HEADER byte then every sample of the memory, ascending) to a UART.
// Latency : tx_start for the header rises on the 2nd clk edge after activate with tx_active low.
// Backpressure: one byte in flight; the next byte waits for tx_done and never starts while tx_active.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   reset  asynchronous active-high reset
//   bus    sample_reader_if.master: activate/done control, mem_addr/mem_oe/mem_data memory read,
//          tx_data/tx_start/tx_active/tx_done UART transmitter handshake
//
// Optional feature: define SAMPLE_READER_CHECKSUM_EN to append one byte after the last sample,
// the XOR of all samples of the frame, sent from a CSUM state that behaves like SEND.
// With the macro undefined there is no CSUM state and no accumulator.
module sample_reader #(
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 8,   // must be 8: samples go straight onto the UART
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  sample_reader_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_READ,
    ST_LATCH,
    ST_SEND,
    ST_WAIT,
`ifdef SAMPLE_READER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_oe_q;
  logic [7:0]            tx_data_q;
  logic                  tx_start_q;
  logic                  done_q;
  // Set while the byte in flight is the header, so its tx_done does not advance addr.
  logic                  hdr_pend_q;
`ifdef SAMPLE_READER_CHECKSUM_EN
  logic [7:0]            csum_q;
  // Set while the byte in flight is the checksum, so its tx_done ends the frame.
  logic                  csum_pend_q;
`endif
  logic                  abort;

  assign addr_d = addr_q + 1'b1;

  // Dropping activate mid-frame abandons it; IDLE and DONE handle activate themselves.
  assign abort = !bus.activate && (state_q != ST_IDLE) && (state_q != ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_oe_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      done_q      <= 1'b0;
      hdr_pend_q  <= 1'b0;
`ifdef SAMPLE_READER_CHECKSUM_EN
      csum_q      <= 8'h00;
      csum_pend_q <= 1'b0;
`endif
    end else begin
      // tx_start is a single-cycle pulse unless a state below re-asserts it.
      tx_start_q <= 1'b0;

      if (abort) begin
        // A byte already handed to the UART simply finishes; we stop issuing new ones.
        state_q  <= ST_IDLE;
        mem_oe_q <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.activate && !bus.tx_active) begin
              addr_q      <= '0;
              hdr_pend_q  <= 1'b1;
`ifdef SAMPLE_READER_CHECKSUM_EN
              csum_q      <= 8'h00;
              csum_pend_q <= 1'b0;
`endif
              state_q     <= ST_HDR;
            end
          end

          ST_HDR: begin
            // Guard keeps tx_start away from a busy transmitter.
            if (!bus.tx_active) begin
              tx_data_q  <= HEADER;
              tx_start_q <= 1'b1;
              state_q    <= ST_WAIT;
            end
          end

          ST_READ: begin
            // Address and output enable were set on entry; one cycle for the memory to settle.
            state_q <= ST_LATCH;
          end

          ST_LATCH: begin
            tx_data_q <= bus.mem_data;
`ifdef SAMPLE_READER_CHECKSUM_EN
            csum_q    <= csum_q ^ bus.mem_data;
`endif
            mem_oe_q  <= 1'b0;
            state_q   <= ST_SEND;
          end

          ST_SEND: begin
            if (!bus.tx_active) begin
              tx_start_q <= 1'b1;
              state_q    <= ST_WAIT;
            end
          end

`ifdef SAMPLE_READER_CHECKSUM_EN
          ST_CSUM: begin
            if (!bus.tx_active) begin
              tx_data_q   <= csum_q;
              tx_start_q  <= 1'b1;
              csum_pend_q <= 1'b1;
              state_q     <= ST_WAIT;
            end
          end
`endif

          ST_WAIT: begin
            // tx_data_q is untouched here so the UART sees a stable byte.
            if (bus.tx_done) begin
              if (hdr_pend_q) begin
                // Header finished: fetch sample 0 without advancing addr.
                hdr_pend_q <= 1'b0;
                mem_addr_q <= addr_q;
                mem_oe_q   <= 1'b1;
                state_q    <= ST_READ;
`ifdef SAMPLE_READER_CHECKSUM_EN
              end else if (csum_pend_q) begin
                csum_pend_q <= 1'b0;
                done_q      <= 1'b1;
                state_q     <= ST_DONE;
`endif
              end else if (addr_q == ADDR_LAST) begin
                // Last sample sent: addr stays put rather than wrapping back to 0.
`ifdef SAMPLE_READER_CHECKSUM_EN
                state_q <= ST_CSUM;
`else
                done_q  <= 1'b1;
                state_q <= ST_DONE;
`endif
              end else begin
                addr_q     <= addr_d;
                mem_addr_q <= addr_d;
                mem_oe_q   <= 1'b1;
                state_q    <= ST_READ;
              end
            end
          end

          ST_DONE: begin
            if (!bus.activate) begin
              done_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end

          default: begin
            state_q  <= ST_IDLE;
            mem_oe_q <= 1'b0;
            done_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // All outputs come straight from registers.
  assign bus.done     = done_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_oe   = mem_oe_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_sample_reader.sv
// Purpose : self-checking bench for sample_reader against a frame-level reference model.
// Latency : checks the 2-edge activate-to-tx_start latency and full-frame content.
// Backpressure: a UART model answers each tx_start with tx_active and a tx_done pulse.
module tb_sample_reader;

  localparam int         AW  = 8;
  localparam int         N   = 1 << AW;
  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  logic reset;

  always #10 clk = ~clk;

  sample_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) bus ();

  sample_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .HEADER(HDR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Asynchronous-read sample memory.
  logic [7:0] mem [N];
  assign bus.mem_data = mem[bus.mem_addr];

  // UART model: busy from the edge after tx_start, tx_done ~10 cycles after the start pulse.
  logic model_active = 1'b0;
  logic model_done   = 1'b0;
  int   model_cnt    = 0;
  logic force_active;
  logic inject_done;

  assign bus.tx_active = model_active | force_active;
  assign bus.tx_done   = model_done | inject_done;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) begin
        model_done   <= 1'b1;
        model_active <= 1'b0;
      end
    end else if (bus.tx_start) begin
      model_active <= 1'b1;
      model_cnt    <= 10;
    end
  end

  // Wire monitor: records every byte started and any protocol violation.
  logic [7:0] got [$];
  int   viol_active = 0;
  int   viol_pulse  = 0;
  logic prev_start  = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_start) begin
      got.push_back(bus.tx_data);
      if (bus.tx_active) viol_active++;
      if (prev_start)    viol_pulse++;
    end
    prev_start = bus.tx_start;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int start;
  int sz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference frame: header, all samples in ascending address order, optional XOR byte.
  task automatic check_frame(input string tag, input int first);
    logic [7:0] exp_q [$];
    logic [7:0] g;
`ifdef SAMPLE_READER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
`endif
    exp_q.push_back(HDR);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(mem[i]);
`ifdef SAMPLE_READER_CHECKSUM_EN
      x ^= mem[i];
`endif
    end
`ifdef SAMPLE_READER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    check({tag, "_len"}, got.size() - first, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (first + i < got.size()) ? got[first + i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'h0, g}, {24'h0, exp_q[i]});
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (bus.done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, bus.done, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"},     bus.done, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_oe"},   bus.mem_oe, 0);
    check({tag, "_tx_data"},  bus.tx_data, 0);
    check({tag, "_tx_start"}, bus.tx_start, 0);
  endtask

  task automatic run_frame(input string tag);
    start = got.size();
    bus.activate = 1'b1;
    @(negedge clk);
    wait_done(tag, 6000);
    check_frame(tag, start);
    bus.activate = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_idle_done"}, bus.done, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    reset        = 1'b1;
    bus.activate = 1'b0;
    force_active = 1'b0;
    inject_done  = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Ramp frame with activate-to-tx_start latency.
    start = got.size();
    bus.activate = 1'b1;
    @(posedge clk); #1;
    check("lat_edge1_start", bus.tx_start, 0);
    @(posedge clk); #1;
    check("lat_edge2_start", bus.tx_start, 1);
    check("lat_hdr_data", bus.tx_data, HDR);
    @(negedge clk);
    wait_done("ramp", 6000);
    check_frame("ramp", start);
    check("ramp_addr_hold", bus.mem_addr, N - 1);
    check("ramp_oe_low", bus.mem_oe, 0);

    // activate held long after done, with a spurious tx_done in DONE.
    sz = got.size();
    for (int c = 0; c < 100; c++) begin
      inject_done = (c == 20);
      @(negedge clk);
    end
    inject_done = 1'b0;
    check("hold_done", bus.done, 1);
    check("hold_no_bytes", got.size(), sz);
    bus.activate = 1'b0;
    @(posedge clk); #1;
    check("done_drop", bus.done, 0);

    // Spurious tx_done in IDLE.
    @(negedge clk);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_spurious_no_bytes", got.size(), sz);

    // Random sample contents.
    for (int f = 0; f < 2; f++) begin
      fill_random();
      run_frame($sformatf("rand%0d", f));
    end

`ifdef SAMPLE_READER_CHECKSUM_EN
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    mem[0] = 8'h3C;
    run_frame("csum3c");
`endif

    // Abort on the 10th byte's tx_done; abort must win over tx_done.
    fill_random();
    start = got.size();
    bus.activate = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (model_done && (got.size() - start == 10)) break;
    end
    check("abort_reach10", got.size() - start, 10);
    check("abort_txdone_seen", bus.tx_done, 1);
    bus.activate = 1'b0;
    @(posedge clk); #1;
    check("abort_start", bus.tx_start, 0);
    check("abort_done", bus.done, 0);
    repeat (40) @(negedge clk);
    check("abort_no_bytes", got.size() - start, 10);
    check("abort_done_later", bus.done, 0);
    run_frame("reactivate");

    // Reset while waiting on the UART mid-frame.
    fill_random();
    start = got.size();
    bus.activate = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ((got.size() - start == 5) && bus.tx_active) break;
    end
    check("midrst_reach5", got.size() - start, 5);
    reset = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    start = got.size();
    reset = 1'b0;
    wait_done("post_rst", 6000);
    check_frame("post_rst", start);
    bus.activate = 1'b0;
    repeat (3) @(negedge clk);

    // Transmitter busy when activate rises.
    fill_random();
    force_active = 1'b1;
    bus.activate = 1'b1;
    sz = got.size();
    repeat (20) @(negedge clk);
    check("busy_no_bytes", got.size(), sz);
    force_active = 1'b0;
    @(posedge clk); #1;
    check("busy_edge1_start", bus.tx_start, 0);
    @(posedge clk); #1;
    check("busy_edge2_start", bus.tx_start, 1);
    @(negedge clk);
    wait_done("busy", 6000);
    check_frame("busy", sz);
    bus.activate = 1'b0;
    repeat (3) @(negedge clk);

    check("start_while_active", viol_active, 0);
    check("start_pulse_width", viol_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
